// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: samples a multiplexed 7-segment bus, qualifies each digit window, decodes it
// back to BCD and emits one frame per scan on valid/ready. Define SEG7_DP_EN to add dp/frame_dp.
module seg7_scan_reader #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   digit,
`ifdef SEG7_DP_EN
  input  logic                    dp,
  output logic [NUM_DIGITS-1:0]   frame_dp,
`endif
  output logic [4*NUM_DIGITS-1:0] frame_bcd,
  output logic [NUM_DIGITS-1:0]   frame_blank,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic                    strobe_err,
  output logic                    link_lost
);

  localparam int SAMP_W = NUM_DIGITS + 8;
  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_QUAL, S_HELD} state_t;

  // Decoded digit: {err, blank, nibble}. Exact pattern match only.
  function automatic logic [5:0] decode(input logic [6:0] pat);
    case (pat)
      7'h00:   decode = {2'b01, 4'h0};
      7'h3F:   decode = {2'b00, 4'd0};
      7'h06:   decode = {2'b00, 4'd1};
      7'h5B:   decode = {2'b00, 4'd2};
      7'h4F:   decode = {2'b00, 4'd3};
      7'h66,
      7'h26:   decode = {2'b00, 4'd4};
      7'h6D:   decode = {2'b00, 4'd5};
      7'h7D:   decode = {2'b00, 4'd6};
      7'h07:   decode = {2'b00, 4'd7};
      7'h7F:   decode = {2'b00, 4'd8};
      7'h6F:   decode = {2'b00, 4'd9};
      default: decode = {2'b10, 4'hF};
    endcase
  endfunction

  logic                    dp_in;
  logic [SAMP_W-1:0]       raw, sync1, samp, samp_q;
  logic [6:0]              seg_s;
  logic [NUM_DIGITS-1:0]   dig_s;
  logic                    dig_one, dig_multi, changed;
  logic [IDX_W-1:0]        cap_idx;
  logic [5:0]              dec;

  state_t                  state, state_next, start_state;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic                    capture, strobe_hit;

  logic [NUM_DIGITS-1:0]   mask, mask_next;
  logic                    frame_hit, done_pend, lost_rise;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [4*NUM_DIGITS-1:0] slot_bcd;
  logic [NUM_DIGITS-1:0]   slot_blank, slot_err;

`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0]   slot_dp;
  assign dp_in = dp ^ (SEG_ACTIVE_LOW != 0);
`else
  assign dp_in = 1'b0;
`endif

  // Polarity is normalised before the synchroniser so everything downstream is active-high.
  assign raw = {dp_in,
                digit ^ {NUM_DIGITS{DIG_ACTIVE_LOW != 0}},
                seg ^ {7{SEG_ACTIVE_LOW != 0}}};

  // NOTE: sequential state always uses <=, so every flop samples the pre-edge value of its source.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      samp   <= '0;
      samp_q <= '0;
    end else begin
      sync1  <= raw;
      samp   <= sync1;
      samp_q <= samp;
    end
  end

  assign seg_s     = samp[6:0];
  assign dig_s     = samp[7 +: NUM_DIGITS];
  assign dig_one   = (dig_s != '0) && ((dig_s & (dig_s - NUM_DIGITS'(1))) == '0);
  assign dig_multi = (dig_s != '0) && !dig_one;
  assign changed   = (samp != samp_q);
  assign dec       = decode(seg_s);

  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_s[i]) cap_idx = IDX_W'(i);
    end
  end

  // Where a fresh window goes when evaluated from scratch.
  assign start_state = dig_one ? S_QUAL : S_IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    strobe_hit = 1'b0;
    case (state)
      S_QUAL: begin
        if (!changed) begin
          if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            capture    = 1'b1;
            state_next = S_HELD;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end else begin
          state_next = start_state;
          cnt_next   = CNT_W'(1);
          strobe_hit = dig_multi;
        end
      end
      S_HELD: begin
        if (changed) begin
          state_next = start_state;
          cnt_next   = CNT_W'(1);
          strobe_hit = dig_multi;
        end
      end
      default: begin
        state_next = start_state;
        cnt_next   = CNT_W'(1);
        strobe_hit = dig_multi;
      end
    endcase
  end

  assign link_lost = (tmo_cnt >= TMO_W'(TIMEOUT_CYCLES));
  assign lost_rise = !capture && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // A completed frame holds the full mask for one cycle; it is cleared when the frame is copied out.
  always_comb begin
    mask_next = mask;
    if (done_pend || lost_rise) mask_next = '0;
    if (capture) mask_next[cap_idx] = 1'b1;
    frame_hit = capture && (mask_next == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: working slots are few flops and are reset too, so frame_* never shows X.
      slot_bcd    <= '0;
      slot_blank  <= '0;
      slot_err    <= '0;
      mask        <= '0;
      done_pend   <= 1'b0;
      tmo_cnt     <= '0;
      frame_bcd   <= '0;
      frame_blank <= '0;
      frame_err   <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      strobe_err  <= 1'b0;
    end else begin
      if (capture) begin
        slot_bcd[{cap_idx, 2'b00} +: 4] <= dec[3:0];
        slot_blank[cap_idx]             <= dec[4];
        slot_err[cap_idx]               <= dec[5];
      end
      mask      <= mask_next;
      done_pend <= frame_hit;

      if (capture)         tmo_cnt <= '0;
      else if (!link_lost) tmo_cnt <= tmo_cnt + 1'b1;

      if (strobe_hit) strobe_err <= 1'b1;

      // A stalled consumer keeps its frame; the newer one is dropped and flagged.
      if (done_pend) begin
        if (out_valid && !out_ready) begin
          overflow <= 1'b1;
        end else begin
          frame_bcd   <= slot_bcd;
          frame_blank <= slot_blank;
          frame_err   <= slot_err;
          out_valid   <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SEG7_DP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_dp  <= '0;
      frame_dp <= '0;
    end else begin
      if (capture) slot_dp[cap_idx] <= samp[SAMP_W-1];
      if (done_pend && !(out_valid && !out_ready)) frame_dp <= slot_dp;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: directed and randomised scans compared against a
// frame-level reference model built from the segment-letter decode table.
module tb_seg7_scan_reader;
  localparam int ND     = 4;
  localparam int STABLE = 4;
  localparam int TMO    = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg;
  logic [ND-1:0] digit;
  logic [4*ND-1:0] frame_bcd;
  logic [ND-1:0] frame_blank, frame_err;
  logic          out_valid, out_ready, overflow, strobe_err, link_lost;

  always #5 clk = ~clk;

  seg7_scan_reader #(
    .NUM_DIGITS(ND), .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .seg(seg), .digit(digit),
    .frame_bcd(frame_bcd), .frame_blank(frame_blank), .frame_err(frame_err),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
    .strobe_err(strobe_err), .link_lost(link_lost)
  );

  typedef struct packed {
    logic [4*ND-1:0] bcd;
    logic [ND-1:0]   blank;
    logic [ND-1:0]   err;
  } frame_t;

  int total = 0;
  int bad   = 0;
  int valid_cycles;
  frame_t obs_q[$];
  frame_t exp_q[$];

  // Reference model state, at frame granularity.
  logic [3:0]    m_bcd [ND];
  logic          m_blank [ND];
  logic          m_err [ND];
  logic [ND-1:0] m_mask;
  logic          m_full, m_ovf;
  frame_t        m_held;

  string seg_names [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic logic [6:0] letters(input string s);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < s.len(); i++) p[int'(s[i]) - 97] = 1'b1;
    return p;
  endfunction

  // {err, blank, nibble}
  function automatic logic [5:0] ref_decode(input logic [6:0] pat);
    if (pat == 7'h00) return {2'b01, 4'h0};
    if (pat == letters("bcf")) return {2'b00, 4'd4};
    for (int v = 0; v < 10; v++)
      if (pat == letters(seg_names[v])) return {2'b00, 4'(v)};
    return {2'b10, 4'hF};
  endfunction

  function automatic logic [6:0] rand_pat();
    int r;
    r = $urandom_range(0, 12);
    if (r < 10) return letters(seg_names[r]);
    if (r == 10) return 7'h00;
    if (r == 11) return letters("bcf");
    return 7'($urandom);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (out_valid) valid_cycles++;
    if (out_valid && out_ready) obs_q.push_back(frame_t'({frame_bcd, frame_blank, frame_err}));
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mask = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    m_held = '0;
    for (int i = 0; i < ND; i++) begin
      m_bcd[i] = 4'h0; m_blank[i] = 1'b0; m_err[i] = 1'b0;
    end
  endtask

  task automatic model_capture(input int idx, input logic [6:0] pat);
    logic [5:0] d;
    frame_t f;
    d = ref_decode(pat);
    m_bcd[idx] = d[3:0]; m_blank[idx] = d[4]; m_err[idx] = d[5];
    m_mask[idx] = 1'b1;
    if (&m_mask) begin
      for (int i = 0; i < ND; i++) begin
        f.bcd[4*i +: 4] = m_bcd[i]; f.blank[i] = m_blank[i]; f.err[i] = m_err[i];
      end
      m_mask = '0;
      if (out_ready)   exp_q.push_back(f);
      else if (m_full) m_ovf = 1'b1;
      else begin
        m_full = 1'b1;
        m_held = f;
      end
    end
  endtask

  task automatic show(input int idx, input logic [6:0] pat, input int hold, input int gap);
    digit = '0;
    digit[idx] = 1'b1;
    seg = pat;
    repeat (hold) tick();
    if (hold >= STABLE) model_capture(idx, pat);
    digit = '0;
    seg = '0;
    repeat (gap) tick();
  endtask

  task automatic flush();
    repeat (8) tick();
  endtask

  task automatic compare_frames(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_frame"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic random_scan();
    int ord [ND];
    int j, t;
    for (int i = 0; i < ND; i++) ord[i] = i;
    for (int i = ND - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    for (int k = 0; k < ND; k++) begin
      if (k < ND - 1 && $urandom_range(0, 3) == 0) show(ord[k], rand_pat(), STABLE + 2, 2);
      if ($urandom_range(0, 3) == 0) show(ord[k], rand_pat(), 2, 2);
      show(ord[k], rand_pat(), $urandom_range(STABLE + 1, 9), $urandom_range(1, 3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; out_ready = 1'b1; digit = '0; seg = '0;
    valid_cycles = 0;
    model_reset();
    repeat (3) tick();
    check("reset_outputs",
          {frame_bcd, frame_blank, frame_err, out_valid, overflow, strobe_err, link_lost}, '0);
    rst = 1'b0;
    repeat (2) tick();

    // Basic scan 1,2,3,4(bcfg).
    valid_cycles = 0;
    show(0, letters("bc"),    10, 2);
    show(1, letters("abdeg"), 10, 2);
    show(2, letters("abcdg"), 10, 2);
    show(3, letters("bcfg"),  10, 2);
    flush();
    check("scan1_bcd",   frame_bcd,   16'h4321);
    check("scan1_blank", frame_blank, 4'h0);
    check("scan1_err",   frame_err,   4'h0);
    check("scan1_valid_cycles", valid_cycles, 1);
    compare_frames("scan1");

    // bcf as 4, blank digit, invalid pattern.
    show(0, letters("abcdef"), 10, 2);
    show(1, letters("bcf"),    10, 2);
    show(2, 7'h00,             10, 2);
    show(3, letters("abcdeg"), 10, 2);
    flush();
    check("scan2_bcd",   frame_bcd,   16'hF040);
    check("scan2_blank", frame_blank, 4'b0100);
    check("scan2_err",   frame_err,   4'b1000);
    compare_frames("scan2");

    // Randomised scans with glitches and recaptures.
    for (int s = 0; s < 4; s++) random_scan();
    flush();
    compare_frames("random");

    // Partial frame, then unstable segments until the link is lost.
    show(0, letters("acdfg"), 8, 2);
    show(1, letters("abc"),   8, 2);
    check("lost_before", link_lost, 1'b0);
    digit = 4'b0001;
    for (int i = 0; i < (TMO + 60) / 3; i++) begin
      seg = (i % 2 == 1) ? letters("abc") : letters("bc");
      repeat (3) tick();
    end
    check("lost_asserted", link_lost, 1'b1);
    m_mask = '0;
    digit = '0; seg = '0;
    repeat (2) tick();
    check("lost_no_frame", obs_q.size(), 0);
    show(2, letters("abcdefg"), 8, 2);
    show(3, letters("abcdfg"),  8, 2);
    flush();
    check("lost_cleared", link_lost, 1'b0);
    compare_frames("lost_partial");
    show(0, letters("acdefg"), 8, 2);
    show(1, letters("abdeg"),  8, 2);
    flush();
    compare_frames("lost_recover");

    // Multi-hot strobe.
    check("strobe_before", strobe_err, 1'b0);
    digit = 4'b0011; seg = letters("abc");
    repeat (8) tick();
    digit = '0; seg = '0;
    flush();
    check("strobe_set", strobe_err, 1'b1);
    compare_frames("strobe_nocap");

    // Stalled consumer across two scans.
    check("ovf_before", overflow, 1'b0);
    out_ready = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int d = 0; d < ND; d++) show(d, rand_pat(), 7, 2);
    flush();
    check("stall_valid", out_valid, 1'b1);
    check("stall_hold", frame_t'({frame_bcd, frame_blank, frame_err}), m_held);
    check("ovf_set", overflow, m_ovf);
    compare_frames("stall_none");
    out_ready = 1'b1;
    if (m_full) begin
      exp_q.push_back(m_held);
      m_full = 1'b0;
    end
    flush();
    compare_frames("stall_release");
    check("stall_valid_drop", out_valid, 1'b0);
    check("strobe_sticky", strobe_err, 1'b1);

    // Reset in the middle of a frame.
    show(0, letters("abcdefg"), 8, 2);
    show(1, letters("abcdefg"), 8, 2);
    rst = 1'b1;
    tick();
    check("midrst_outputs",
          {frame_bcd, frame_blank, frame_err, out_valid, overflow, strobe_err, link_lost}, '0);
    repeat (2) tick();
    check("midrst_outputs2",
          {frame_bcd, frame_blank, frame_err, out_valid, overflow, strobe_err, link_lost}, '0);
    rst = 1'b0;
    model_reset();
    obs_q.delete();
    repeat (2) tick();
    show(2, letters("bc"),     8, 2);
    show(3, letters("abc"),    8, 2);
    show(0, letters("acdfg"),  8, 2);
    check("midrst_partial", obs_q.size(), 0);
    show(1, letters("abcdg"),  8, 2);
    flush();
    check("midrst_bcd", frame_bcd, 16'h7135);
    compare_frames("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
